// File: rtl/riscv_pkg.sv
// Shared RV32 execute-stage definitions: RV32M funct3 codes, MD FSM states,
// forward-select / Op1-source encodings, ALU ops and branch conditions.
// No ports; imported by execute_md, md_divider and riscv_alu.
package riscv_pkg;

    // RV32M funct3 encodings (bit 2 set = divide family)
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_DONE = 2'b11
    } md_state_t;

    // Forwarding mux selects (11 behaves like 00)
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    // Op1 source selects (11 behaves like 00)
    localparam logic [1:0] OP1_RS1  = 2'b00;
    localparam logic [1:0] OP1_PC   = 2'b01;
    localparam logic [1:0] OP1_ZERO = 2'b10;

    // ALU operations
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    // Branch conditions (mirror the RV32I branch funct3)
    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    function automatic logic md_is_div(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/md_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, DIV_BITS bits per cycle.
// Ports: start captures dividend/divisor/is_signed; kill aborts; last is high in
// the final iteration cycle; quotient/remainder are sign-corrected and valid after it.
module md_divider
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_BITS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  kill,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  is_signed,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int N  = DATA_WIDTH / DIV_BITS;
    localparam int CW = $clog2(N + 1);
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic                  busy_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_q;
    logic                  neg_q_q, neg_r_q, div0_q, ovf_q;

    logic [DATA_WIDTH-1:0] rem_n, quo_n;
    logic [DATA_WIDTH:0]   tmp;
    logic                  neg_a, neg_b;

    assign neg_a = is_signed & dividend[DATA_WIDTH-1];
    assign neg_b = is_signed & divisor[DATA_WIDTH-1];

    // DIV_BITS restoring steps on magnitudes; quo_q shifts the dividend out at the
    // top while quotient bits enter at the bottom.
    always_comb begin
        rem_n = rem_q;
        quo_n = quo_q;
        tmp   = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            tmp   = {rem_n, quo_n[DATA_WIDTH-1]};
            quo_n = {quo_n[DATA_WIDTH-2:0], 1'b0};
            if (tmp >= {1'b0, dvs_q}) begin
                tmp      = tmp - {1'b0, dvs_q};
                quo_n[0] = 1'b1;
            end
            rem_n = tmp[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (start) begin
            busy_q  <= 1'b1;
            cnt_q   <= CW'(N);
            rem_q   <= '0;
            quo_q   <= neg_a ? -dividend : dividend;
            dvs_q   <= neg_b ? -divisor : divisor;
            dvd_q   <= dividend;
            neg_q_q <= neg_a ^ neg_b;
            neg_r_q <= neg_a;
            // Corner cases are only flagged here; the iteration count is unchanged
            // so the latency stays fixed.
            div0_q  <= (divisor == '0);
            ovf_q   <= is_signed & (dividend == MIN_VAL) & (divisor == '1);
        end else if (busy_q) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign last = busy_q && (cnt_q == CW'(1));

    always_comb begin
        if (div0_q) begin
            quotient  = '1;
            remainder = dvd_q;
        end else if (ovf_q) begin
            quotient  = MIN_VAL;
            remainder = '0;
        end else begin
            quotient  = neg_q_q ? -quo_q : quo_q;
            remainder = neg_r_q ? -rem_q : rem_q;
        end
    end

endmodule

// File: rtl/riscv_alu.sv
// Combinational integer ALU plus branch comparator.
// Ports: a/b ALU operands, ctrl op select -> result; cmp_a/cmp_b compared
// under branch_src -> cond (branch condition true).
module riscv_alu
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [3:0]            ctrl,
    input  logic [DATA_WIDTH-1:0] cmp_a,
    input  logic [DATA_WIDTH-1:0] cmp_b,
    input  logic [2:0]            branch_src,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  cond
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0] shamt;
    logic           eq;
    logic           lt;
    logic           ltu;

    assign shamt = b[SHW-1:0];
    assign eq    = (cmp_a == cmp_b);
    assign lt    = ($signed(cmp_a) < $signed(cmp_b));
    assign ltu   = (cmp_a < cmp_b);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_SLT:   result = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {{(DATA_WIDTH-1){1'b0}}, a < b};
            ALU_SLL:   result = a << shamt;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = DATA_WIDTH'($signed(a) >>> shamt);
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (branch_src)
            BR_EQ:   cond = eq;
            BR_NE:   cond = !eq;
            BR_LT:   cond = lt;
            BR_GE:   cond = !lt;
            BR_LTU:  cond = ltu;
            BR_GEU:  cond = !ltu;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_md.sv
// RV32 execute stage: forwarding, Op1/ALU-source muxes, branch resolution and an
// RV32M multiply/divide unit that stalls E until its result is ready.
// Ports: ID/EX operands and controls in; result, store data, redirect, stall and MD-done out.
module execute_md
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ValidE_i,
    input  logic                  FlushE_i,
    input  logic [DATA_WIDTH-1:0] RD1E_i,
    input  logic [DATA_WIDTH-1:0] RD2E_i,
    input  logic [DATA_WIDTH-1:0] PCE_i,
    input  logic [DATA_WIDTH-1:0] ImmExtE_i,
    input  logic [DATA_WIDTH-1:0] PCPlus4E_i,
    input  logic [4:0]            RdE_i,
    input  logic [4:0]            Rs1E_i,
    input  logic [4:0]            Rs2E_i,
    input  logic [DATA_WIDTH-1:0] ResultW_i,
    input  logic [DATA_WIDTH-1:0] ALUResultM_i,
    input  logic [1:0]            ForwardAEctrl_i,
    input  logic [1:0]            ForwardBEctrl_i,
    input  logic [1:0]            Op1SrcE_i,
    input  logic                  ALUSrcE_i,
    input  logic [3:0]            ALUCtrlE_i,
    input  logic [2:0]            BranchSrc_i,
    input  logic                  BranchE_i,
    input  logic                  JumpE_i,
    input  logic                  PredictTakenE_i,
    input  logic                  MDOpE_i,
    input  logic [2:0]            MDFunct3E_i,
    output logic [DATA_WIDTH-1:0] ALUResultE_o,
    output logic [DATA_WIDTH-1:0] WriteDataE_o,
    output logic [DATA_WIDTH-1:0] PCPlus4E_o,
    output logic [DATA_WIDTH-1:0] PCTargetE_o,
    output logic [4:0]            RdE_o,
    output logic [4:0]            Rs1E_o,
    output logic [4:0]            Rs2E_o,
    output logic                  branchTaken_o,
    output logic                  PCSrcE_o,
    output logic                  StallE_o,
    output logic                  MDDoneE_o
);

    localparam int DW  = DATA_WIDTH;
    localparam int MCW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    // ---------------- combinational datapath ----------------
    logic [DW-1:0] fwd_a, write_data, src_a, src_b, alu_result;
    logic          actual_taken;

    always_comb begin
        case (ForwardAEctrl_i)
            FWD_W:   fwd_a = ResultW_i;
            FWD_M:   fwd_a = ALUResultM_i;
            default: fwd_a = RD1E_i;
        endcase
        case (ForwardBEctrl_i)
            FWD_W:   write_data = ResultW_i;
            FWD_M:   write_data = ALUResultM_i;
            default: write_data = RD2E_i;
        endcase
        case (Op1SrcE_i)
            OP1_PC:   src_a = PCE_i;
            OP1_ZERO: src_a = '0;
            default:  src_a = fwd_a;
        endcase
    end

    assign src_b = ALUSrcE_i ? ImmExtE_i : write_data;

    riscv_alu #(.DATA_WIDTH(DW)) u_alu (
        .a          (src_a),
        .b          (src_b),
        .ctrl       (ALUCtrlE_i),
        .cmp_a      (fwd_a),
        .cmp_b      (write_data),
        .branch_src (BranchSrc_i),
        .result     (alu_result),
        .cond       (branchTaken_o)
    );

    assign actual_taken = (BranchE_i & branchTaken_o) | JumpE_i;
    assign PCSrcE_o     = actual_taken != PredictTakenE_i;
    assign PCTargetE_o  = actual_taken ? (JumpE_i ? alu_result : PCE_i + ImmExtE_i)
                                       : PCPlus4E_i;

    assign WriteDataE_o = write_data;
    assign PCPlus4E_o   = PCPlus4E_i;
    assign RdE_o        = RdE_i;
    assign Rs1E_o       = Rs1E_i;
    assign Rs2E_o       = Rs2E_i;

    // ---------------- MD control FSM ----------------
    md_state_t      state_q, state_d;
    logic [MCW-1:0] mul_cnt_q;
    logic [DW-1:0]  a_q, b_q;
    logic [2:0]     f3_q;
    logic           md_start, md_stall, md_done;
    logic           div_last;
    logic [DW-1:0]  div_quo, div_rem;

    // Flush beats a same-cycle start; the op is simply never captured.
    assign md_start = ValidE_i & MDOpE_i & !FlushE_i & (state_q == MD_IDLE);

    always_comb begin
        state_d  = state_q;
        md_stall = 1'b0;
        md_done  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    md_stall = 1'b1;
                    if (md_is_div(MDFunct3E_i)) begin
                        state_d = MD_DIV;
                    end else if (MUL_LATENCY == 1) begin
                        state_d = MD_DONE;
                    end else begin
                        state_d = MD_MUL;
                    end
                end
            end
            MD_MUL: begin
                md_stall = 1'b1;
                if (mul_cnt_q == MCW'(MUL_LATENCY - 1)) begin
                    state_d = MD_DONE;
                end
            end
            MD_DIV: begin
                md_stall = 1'b1;
                if (div_last) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                md_done = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        if (FlushE_i || rst) begin
            state_d  = MD_IDLE;
            md_stall = 1'b0;
            md_done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            mul_cnt_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            f3_q      <= '0;
        end else begin
            state_q <= state_d;
            // Forwarded operands are only valid in the start cycle; hold them here.
            if (md_start) begin
                a_q       <= src_a;
                b_q       <= write_data;
                f3_q      <= MDFunct3E_i;
                mul_cnt_q <= MCW'(1);
            end else if (state_q == MD_MUL) begin
                mul_cnt_q <= mul_cnt_q + 1'b1;
            end
        end
    end

    assign StallE_o  = md_stall;
    assign MDDoneE_o = md_done;

    // ---------------- multiplier ----------------
    // Operands are sign-extended to 2*DW as their funct3 demands; the low 2*DW
    // bits of that product are the exact signed/unsigned full product.
    logic          mul_sa, mul_sb;
    logic [2*DW-1:0] a_wide, b_wide, prod_comb, prod_out;

    assign mul_sa    = (f3_q == F3_MULH) || (f3_q == F3_MULHSU);
    assign mul_sb    = (f3_q == F3_MULH);
    assign a_wide    = {{DW{mul_sa & a_q[DW-1]}}, a_q};
    assign b_wide    = {{DW{mul_sb & b_q[DW-1]}}, b_q};
    assign prod_comb = a_wide * b_wide;

    // Capture register plus MUL_LATENCY-1 pipeline stages gives a result in the
    // DONE cycle, MUL_LATENCY cycles after capture.
    if (MUL_LATENCY > 1) begin : g_mul_pipe
        logic [2*DW-1:0] pipe_q [MUL_LATENCY-1];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < MUL_LATENCY - 1; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= prod_comb;
                for (int i = 1; i < MUL_LATENCY - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end
        assign prod_out = pipe_q[MUL_LATENCY-2];
    end else begin : g_mul_comb
        assign prod_out = prod_comb;
    end

    // ---------------- divider ----------------
    md_divider #(.DATA_WIDTH(DW), .DIV_BITS(DIV_BITS)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start & md_is_div(MDFunct3E_i)),
        .kill      (FlushE_i),
        .dividend  (src_a),
        .divisor   (write_data),
        .is_signed (!MDFunct3E_i[0]),
        .last      (div_last),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // ---------------- result select ----------------
    logic [DW-1:0] md_result;

    always_comb begin
        if (md_is_div(f3_q)) begin
            md_result = f3_q[1] ? div_rem : div_quo;
        end else if (f3_q == F3_MUL) begin
            md_result = prod_out[DW-1:0];
        end else begin
            md_result = prod_out[2*DW-1:DW];
        end
    end

    assign ALUResultE_o = (state_q == MD_DONE) ? md_result : alu_result;

endmodule

// File: tb/tb_execute_md.sv
module tb_execute_md;

    localparam int DW   = 32;
    localparam int ML   = 2;
    localparam int DB   = 1;
    localparam int NDIV = DW / DB;

    logic          clk = 1'b0;
    logic          rst;
    logic          ValidE_i, FlushE_i;
    logic [DW-1:0] RD1E_i, RD2E_i, PCE_i, ImmExtE_i, PCPlus4E_i;
    logic [4:0]    RdE_i, Rs1E_i, Rs2E_i;
    logic [DW-1:0] ResultW_i, ALUResultM_i;
    logic [1:0]    ForwardAEctrl_i, ForwardBEctrl_i, Op1SrcE_i;
    logic          ALUSrcE_i;
    logic [3:0]    ALUCtrlE_i;
    logic [2:0]    BranchSrc_i;
    logic          BranchE_i, JumpE_i, PredictTakenE_i, MDOpE_i;
    logic [2:0]    MDFunct3E_i;
    logic [DW-1:0] ALUResultE_o, WriteDataE_o, PCPlus4E_o, PCTargetE_o;
    logic [4:0]    RdE_o, Rs1E_o, Rs2E_o;
    logic          branchTaken_o, PCSrcE_o, StallE_o, MDDoneE_o;

    execute_md #(.DATA_WIDTH(DW), .MUL_LATENCY(ML), .DIV_BITS(DB)) dut (
        .clk(clk), .rst(rst), .ValidE_i(ValidE_i), .FlushE_i(FlushE_i),
        .RD1E_i(RD1E_i), .RD2E_i(RD2E_i), .PCE_i(PCE_i), .ImmExtE_i(ImmExtE_i),
        .PCPlus4E_i(PCPlus4E_i), .RdE_i(RdE_i), .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i),
        .ResultW_i(ResultW_i), .ALUResultM_i(ALUResultM_i),
        .ForwardAEctrl_i(ForwardAEctrl_i), .ForwardBEctrl_i(ForwardBEctrl_i),
        .Op1SrcE_i(Op1SrcE_i), .ALUSrcE_i(ALUSrcE_i), .ALUCtrlE_i(ALUCtrlE_i),
        .BranchSrc_i(BranchSrc_i), .BranchE_i(BranchE_i), .JumpE_i(JumpE_i),
        .PredictTakenE_i(PredictTakenE_i), .MDOpE_i(MDOpE_i), .MDFunct3E_i(MDFunct3E_i),
        .ALUResultE_o(ALUResultE_o), .WriteDataE_o(WriteDataE_o), .PCPlus4E_o(PCPlus4E_o),
        .PCTargetE_o(PCTargetE_o), .RdE_o(RdE_o), .Rs1E_o(Rs1E_o), .Rs2E_o(Rs2E_o),
        .branchTaken_o(branchTaken_o), .PCSrcE_o(PCSrcE_o), .StallE_o(StallE_o),
        .MDDoneE_o(MDDoneE_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] md_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sbv, ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ub  = longint'({32'b0, b});
        case (f3)
            3'd0: begin p = 64'(sa * sbv); return p[31:0]; end
            3'd1: begin p = 64'(sa * sbv); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub);  return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sbv);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sbv);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic string f3_name(input logic [2:0] f3);
        case (f3)
            3'd0: return "mul";   3'd1: return "mulh";
            3'd2: return "mulhsu"; 3'd3: return "mulhu";
            3'd4: return "div";   3'd5: return "divu";
            3'd6: return "rem";   default: return "remu";
        endcase
    endfunction

    function automatic logic [31:0] pick_opnd();
        case ($urandom_range(0, 7))
            4: return 32'h0;
            5: return 32'hFFFF_FFFF;
            6: return 32'h8000_0000;
            7: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every MD-done cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && MDDoneE_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_md_done actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_result"}, ALUResultE_o, mon_e.res);
                check({mon_e.name, "_done_cycle"}, cyc, mon_e.cyc);
                check({mon_e.name, "_stall_in_done"}, {31'b0, StallE_o}, 32'd0);
            end
        end
    end

    task automatic drive_idle();
        ValidE_i = 0; FlushE_i = 0; MDOpE_i = 0; MDFunct3E_i = 0;
        RD1E_i = 0; RD2E_i = 0; PCE_i = 0; ImmExtE_i = 0; PCPlus4E_i = 0;
        RdE_i = 5'd3; Rs1E_i = 5'd1; Rs2E_i = 5'd2; ResultW_i = 0; ALUResultM_i = 0;
        ForwardAEctrl_i = 0; ForwardBEctrl_i = 0; Op1SrcE_i = 0; ALUSrcE_i = 0;
        ALUCtrlE_i = 4'b0000; BranchSrc_i = 0; BranchE_i = 0; JumpE_i = 0;
        PredictTakenE_i = 0;
    endtask

    // Issue one MD op and follow it to its DONE cycle, checking the stall each cycle.
    // Operand sources are scrambled after the start cycle.
    task automatic md_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int lat;
        int c;
        string nm;
        nm  = f3_name(f3);
        lat = f3[2] ? NDIV + 1 : ML;
        @(posedge clk); #1;
        ValidE_i = 1; MDOpE_i = 1; MDFunct3E_i = f3; FlushE_i = 0;
        ALUCtrlE_i = 4'b0000; ALUSrcE_i = 0; Op1SrcE_i = 2'b00;
        BranchE_i = 0; JumpE_i = 0; PredictTakenE_i = 0;
        if ($urandom_range(0, 1) == 1) begin
            ForwardAEctrl_i = 2'b10; ALUResultM_i = a; RD1E_i = $urandom;
        end else begin
            ForwardAEctrl_i = 2'b00; RD1E_i = a; ALUResultM_i = $urandom;
        end
        if ($urandom_range(0, 1) == 1) begin
            ForwardBEctrl_i = 2'b01; ResultW_i = b; RD2E_i = $urandom;
        end else begin
            ForwardBEctrl_i = 2'b00; RD2E_i = b; ResultW_i = $urandom;
        end
        c = cyc;
        sb.push_back('{md_model(f3, a, b), c + lat, nm});
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            check({nm, "_stall"}, {31'b0, StallE_o}, (k < lat) ? 32'd1 : 32'd0);
            if (k < lat) begin
                @(posedge clk); #1;
                RD1E_i = $urandom; RD2E_i = $urandom;
                ResultW_i = $urandom; ALUResultM_i = $urandom;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, rpc, rimm, ea, eb, exp_alu;
        logic [1:0]  o1;
        logic        asrc;
        logic [3:0]  op;

        drive_idle();
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_stall", {31'b0, StallE_o}, 32'd0);
        check("reset_md_done", {31'b0, MDDoneE_o}, 32'd0);

        // ADD with M-stage forwarding
        @(posedge clk); #1;
        ValidE_i = 1; ForwardAEctrl_i = 2'b10; ALUResultM_i = 32'd5; RD1E_i = 32'd99;
        RD2E_i = 32'd7; ALUCtrlE_i = 4'b0000;
        @(negedge clk);
        check("add_fwd_result", ALUResultE_o, 32'd12);
        check("add_fwd_stall", {31'b0, StallE_o}, 32'd0);
        check("add_writedata", WriteDataE_o, 32'd7);
        check("rd_passthru", {27'b0, RdE_o}, 32'd3);

        // BEQ taken, predicted not taken
        @(posedge clk); #1;
        drive_idle(); ValidE_i = 1;
        RD1E_i = 32'h55; RD2E_i = 32'h55; BranchE_i = 1; BranchSrc_i = 3'b000;
        PCE_i = 32'h1000; ImmExtE_i = 32'h40; PCPlus4E_i = 32'h1004; ALUCtrlE_i = 4'b0001;
        @(negedge clk);
        check("beq_taken_cond", {31'b0, branchTaken_o}, 32'd1);
        check("beq_pcsrc", {31'b0, PCSrcE_o}, 32'd1);
        check("beq_target", PCTargetE_o, 32'h1040);

        // BNE not taken, predicted taken -> redirect to PC+4
        @(posedge clk); #1;
        BranchSrc_i = 3'b001; PredictTakenE_i = 1;
        @(negedge clk);
        check("bne_pcsrc", {31'b0, PCSrcE_o}, 32'd1);
        check("bne_target", PCTargetE_o, 32'h1004);

        // JALR predicted taken: no mispredict, target from ALU
        @(posedge clk); #1;
        BranchE_i = 0; JumpE_i = 1; RD1E_i = 32'h2000; ImmExtE_i = 32'h10;
        ALUSrcE_i = 1; ALUCtrlE_i = 4'b0000;
        @(negedge clk);
        check("jalr_pcsrc", {31'b0, PCSrcE_o}, 32'd0);
        check("jalr_target", PCTargetE_o, 32'h2010);

        // Random non-MD ALU ops through the Op1 and SrcB muxes
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            drive_idle(); ValidE_i = 1;
            ra = $urandom; rb = $urandom; rpc = $urandom; rimm = $urandom;
            o1 = 2'($urandom_range(0, 3)); asrc = 1'($urandom_range(0, 1));
            op = (i % 3 == 0) ? 4'b0000 : (i % 3 == 1) ? 4'b0001 : 4'b0100;
            RD1E_i = ra; RD2E_i = rb; PCE_i = rpc; ImmExtE_i = rimm;
            Op1SrcE_i = o1; ALUSrcE_i = asrc; ALUCtrlE_i = op;
            ea = (o1 == 2'b01) ? rpc : (o1 == 2'b10) ? 32'h0 : ra;
            eb = asrc ? rimm : rb;
            exp_alu = (op == 4'b0000) ? ea + eb : (op == 4'b0001) ? ea - eb : ea ^ eb;
            @(negedge clk);
            check("alu_random", ALUResultE_o, exp_alu);
        end

        // Directed MD ops
        md_op(3'd1, 32'h8000_0000, 32'h8000_0000);
        md_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        md_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        md_op(3'd5, 32'd9, 32'd0);
        md_op(3'd6, 32'd9, 32'd0);
        md_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        md_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Flush a divide in its cycle 10
        @(posedge clk); #1;
        drive_idle(); ValidE_i = 1; MDOpE_i = 1; MDFunct3E_i = 3'd4;
        RD1E_i = 32'd1000; RD2E_i = 32'd7;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("flush_pre_stall", {31'b0, StallE_o}, 32'd1);
            @(posedge clk); #1;
        end
        FlushE_i = 1;
        @(negedge clk);
        check("flush_stall", {31'b0, StallE_o}, 32'd0);
        check("flush_md_done", {31'b0, MDDoneE_o}, 32'd0);
        @(posedge clk); #1;
        drive_idle();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("post_flush_stall", {31'b0, StallE_o}, 32'd0);
        end
        md_op(3'd0, 32'd3, 32'd4);

        // Back-to-back multiplies
        md_op(3'd0, 32'd6, 32'd7);
        md_op(3'd0, 32'd2, 32'd3);

        // Randomised MD ops, occasionally separated by idle cycles
        for (int i = 0; i < 30; i++) begin
            md_op(3'($urandom_range(0, 7)), pick_opnd(), pick_opnd());
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                drive_idle();
            end
        end

        @(posedge clk); #1;
        drive_idle();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_md.md
Name: execute_md

Overview:
Next-generation execute stage for the 5-stage RV32 pipeline. It keeps operand forwarding, Op1/ALU source selection, branch resolution and misprediction recovery. It adds an RV32M multiply/divide unit: a pipelined multiplier and an iterative divider, controlled by an FSM with a stall handshake to the hazard unit. It sits between the ID/EX and EX/MEM pipeline registers.

Parameters:
DATA_WIDTH, 32, datapath width
MUL_LATENCY, 2, multiplier cycles from operand capture to result (>=1)
DIV_BITS, 1, quotient bits retired per divider cycle; must divide DATA_WIDTH

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ValidE_i  in  1  E holds a real (non-bubble) instruction
FlushE_i  in  1  kill the current E instruction, including any MD op in flight
RD1E_i, RD2E_i, PCE_i, ImmExtE_i, PCPlus4E_i  in  DATA_WIDTH  operands, PC, immediate, PC+4
RdE_i, Rs1E_i, Rs2E_i  in  5  register indices
ResultW_i, ALUResultM_i  in  DATA_WIDTH  forwarding sources
ForwardAEctrl_i, ForwardBEctrl_i  in  2  00 reg, 01 W, 10 M, 11 reg
Op1SrcE_i  in  2  00 rs1, 01 PC, 10 zero, 11 rs1
ALUSrcE_i  in  1  SrcB = immediate
ALUCtrlE_i  in  4  ALU op
BranchSrc_i  in  3  branch condition
BranchE_i, JumpE_i, PredictTakenE_i  in  1  branch, jump, predicted-taken
MDOpE_i  in  1  instruction is RV32M
MDFunct3E_i  in  3  MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
ALUResultE_o, WriteDataE_o, PCPlus4E_o, PCTargetE_o  out  DATA_WIDTH  result, store data, PC+4, redirect target
RdE_o, Rs1E_o, Rs2E_o  out  5  pass-through
branchTaken_o, PCSrcE_o  out  1  condition true; mispredict/redirect
StallE_o  out  1  hold F/D/E and bubble M
MDDoneE_o  out  1  MD result valid this cycle

Behaviour:
- Non-MD path is combinational. SrcA = forward mux, then Op1 mux. WriteData = forward-B mux. SrcB = ALUSrc ? Imm : WriteData.
- Branch/jump resolution: ActualTaken = (BranchE_i & branchTaken_o) | JumpE_i. PCSrcE_o = ActualTaken != PredictTakenE_i.
- Redirect target: PCTargetE_o = ActualTaken ? (JumpE_i ? ALU result : PC+Imm) : PC+4.
- ALU and branch-compare internals are an existing sub-module instance.
- MD FSM states: IDLE, MUL, DIV, DONE. Reset -> IDLE with internal counters cleared. After reset, StallE_o=0 and MDDoneE_o=0.
- IDLE with ValidE_i & MDOpE_i & !FlushE_i (cycle 0):
  - Latch forwarded SrcA and WriteData. Forwarded values change while E stalls, so they must be captured here.
  - Latch funct3. Assert StallE_o combinationally.
  - Go to MUL (funct3[2]=0) or DIV.
- MUL: 2*DATA_WIDTH signed/unsigned product, pipelined over MUL_LATENCY cycles. Go to DONE in cycle MUL_LATENCY, so the op spends MUL_LATENCY+1 cycles in E.
  - MUL returns the low half.
  - MULH/MULHSU/MULHU return the high half with s*s, s*u and u*u operand signs.
- DIV: unsigned restoring divider on operand magnitudes, DIV_BITS quotient bits per cycle, N = DATA_WIDTH/DIV_BITS cycles. Sign correction in the DONE cycle (DONE at cycle N+1).
  - Quotient sign = signA ^ signB. Remainder sign = signA.
  - Divide by zero: quotient all-ones, remainder = dividend. Applies to signed and unsigned forms.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
  - Zero divisor and overflow are flagged at capture and resolved in DONE without skipping the iteration count (fixed latency).
- DONE:
  - StallE_o=0, MDDoneE_o=1, ALUResultE_o = MD result (overrides the ALU).
  - Next state IDLE unconditionally; the instruction advances this cycle.
  - A back-to-back MD op is captured in the following IDLE cycle.
- StallE_o=1 in cycle 0 and every MUL/DIV cycle. StallE_o=0 in IDLE without a new MD op, and in DONE.
- MD ops never redirect: the branch path is evaluated with BranchE_i=JumpE_i=0 as decoded.
- FlushE_i in any state: next state IDLE, StallE_o=0 that cycle, no MDDoneE_o, result discarded. Flush has priority over the cycle-0 start.
- rst mid-operation: same as flush, plus all state cleared.
- ValidE_i=0 ignores MDOpE_i.

Decomposition:
- Shared package (riscv_pkg): MD funct3 encodings, md_state_t enum, forward-select and Op1Src encodings.
- One natural sub-module, md_divider: iterative divider with start, done and div-by-zero/overflow handling.
- The multiplier stays inline as a shift-register pipeline.

Test Plan:
- ADD, forwarding: ForwardA=10, ALUResultM=5, RD2=7 -> ALUResultE_o=12 combinationally; StallE_o=0.
- MULH: A=0x80000000, B=0x80000000, MUL_LATENCY=2 -> StallE_o high for cycles 0-1; cycle 2 MDDoneE_o=1, ALUResultE_o=0x40000000.
- Signed divide (DIV_BITS=1):
  - DIV -7/2 -> -3 (0xFFFFFFFD) at cycle 33.
  - REM -7/2 -> 0xFFFFFFFF.
  - StallE_o high for cycles 0-32.
- Divide corner cases: DIVU 9/0 -> 0xFFFFFFFF; REM 9/0 -> 9; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
- Abort: FlushE_i at DIV cycle 10 -> StallE_o=0 that cycle, FSM IDLE next, no MDDoneE_o. A fresh MUL 3*4 then completes with 12.
- Back-to-back and branch: MUL 6*7 then MUL 2*3 -> results 42 and 6 with DONE cycles MUL_LATENCY+1 apart. BEQ taken with PredictTaken=0 -> PCSrcE_o=1, PCTargetE_o=PC+Imm.
